// File: rtl/fixed_float_pipe.sv
// fixed_float_pipe
//   Three-stage pipelined converter from signed fixed-point Q(W-1-Q, Q) to
//   IEEE-754 single precision. Truncate or round-to-nearest-even is chosen per
//   transaction. Valid/ready handshake on both sides, and one global stall.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (clears valids and outputs)
//   in_valid     input transaction present
//   in_ready     converter accepts a transaction this cycle
//   fixed_point  W-bit two's complement operand, value = fixed_point / 2^Q
//   round_mode   0 = truncate toward zero, 1 = round to nearest, ties to even
//   out_valid    result present
//   out_ready    downstream accepts the result
//   ieee_float   single-precision result (+0 for a zero input)
//   inexact      nonzero bits were discarded during normalisation
//   zero         the input was exactly zero
module fixed_float_pipe #(
    parameter int W = 32,
    parameter int Q = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] fixed_point,
    input  logic         round_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  ieee_float,
    output logic         inexact,
    output logic         zero
);
    localparam int PW = $clog2(W);
    localparam logic [PW:0] W_SH = (PW+1)'(W);

    if (W < 8 || W > 64) begin : g_bad_w
        $error("fixed_float_pipe: W=%0d outside 8..64", W);
    end
    if (Q < 0 || Q > W - 1) begin : g_bad_q
        $error("fixed_float_pipe: Q=%0d outside 0..W-1", Q);
    end
    if (W - 1 - Q > 127) begin : g_bad_range
        $error("fixed_float_pipe: integer bits W-1-Q exceed 127");
    end

    // Index of the most significant set bit; 0 for an all-zero vector.
    function automatic logic [PW-1:0] lead_one(input logic [W-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    // Returns {carry, mantissa}. A carry leaves the mantissa at zero, which is
    // exactly the renormalised value once the exponent is bumped.
    function automatic logic [23:0] round_mant(input logic [22:0] m,
                                               input logic guard_b,
                                               input logic sticky_b,
                                               input logic rne);
        logic inc;
        inc = rne & guard_b & (sticky_b | m[0]);
        return {1'b0, m} + 24'(inc);
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic                vld_p0, vld_p1;
    logic                sign_p0, rm_p0;
    logic        [W-1:0] mag_p0;
    logic                sign_p1, rm_p1, zero_p1;
    logic        [W-1:0] mag_p1;
    logic       [PW-1:0] lead_p1;

    logic signed [W-1:0] fx;
    logic        [W-1:0] mag_in;

    // Stage 1: sign and magnitude. Negating the most negative value wraps to
    // 2^(W-1), which is the correct unsigned magnitude.
    assign fx     = fixed_point;
    assign mag_in = fx[W-1] ? $unsigned(-fx) : $unsigned(fx);

    // Stage 3: normalise and round. frac holds the bits below the leading one,
    // MSB-aligned; padding below it keeps the slices valid for W < 24.
    logic     [PW:0] shamt;
    logic    [W-1:0] frac;
    logic  [W+23:0]  ext;
    logic     [22:0] mant;
    logic            guard_c, sticky_c;
    logic     [23:0] rnd;
    logic      [7:0] exp_f;
    logic     [31:0] res_float;
    logic            res_inexact;

    always_comb begin
        shamt       = W_SH - {1'b0, lead_p1};
        frac        = mag_p1 << shamt;
        ext         = {frac, 24'd0};
        mant        = ext[W+23:W+1];
        guard_c     = ext[W];
        sticky_c    = |ext[W-1:0];
        rnd         = round_mant(mant, guard_c, sticky_c, rm_p1);
        exp_f       = 8'(127 - Q + int'(lead_p1)) + 8'(rnd[23]);
        res_float   = zero_p1 ? 32'd0 : {sign_p1, exp_f, rnd[22:0]};
        res_inexact = !zero_p1 && (guard_c || sticky_c);
    end

    // Control and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            out_valid  <= 1'b0;
            ieee_float <= '0;
            inexact    <= 1'b0;
            zero       <= 1'b0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            out_valid <= vld_p1;
            if (vld_p1) begin
                ieee_float <= res_float;
                inexact    <= res_inexact;
                zero       <= zero_p1;
            end
        end
    end

    // Datapath registers: stage 1 -> p0, stage 2 -> p1
    always_ff @(posedge clk) begin
        if (en) begin
            if (in_valid) begin
                sign_p0 <= fx[W-1];
                mag_p0  <= mag_in;
                rm_p0   <= round_mode;
            end
            if (vld_p0) begin
                sign_p1 <= sign_p0;
                mag_p1  <= mag_p0;
                rm_p1   <= rm_p0;
                lead_p1 <= lead_one(mag_p0);
                zero_p1 <= (mag_p0 == '0);
            end
        end
    end

endmodule

// File: tb/tb_fixed_float_pipe.sv
module tb_fixed_float_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: W=32 Q=16, index 1: W=16 Q=8, index 2: W=64 Q=0
    logic [2:0]        iv, ir, rmq, ov, ordy, inx, zr;
    logic [2:0][63:0]  fp;
    logic [2:0][31:0]  f;

    int total = 0;
    int bad   = 0;

    logic [33:0] fifo [3][256];
    int          wr [3];
    int          rd [3];
    bit          hv [3];
    logic [33:0] hold [3];
    logic [33:0] mon_cur;
    bit          rnd_on;

    fixed_float_pipe #(.W(32), .Q(16)) u32 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .fixed_point(fp[0][31:0]), .round_mode(rmq[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .ieee_float(f[0]), .inexact(inx[0]), .zero(zr[0]));

    fixed_float_pipe #(.W(16), .Q(8)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .fixed_point(fp[1][15:0]), .round_mode(rmq[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .ieee_float(f[1]), .inexact(inx[1]), .zero(zr[1]));

    fixed_float_pipe #(.W(64), .Q(0)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .fixed_point(fp[2]), .round_mode(rmq[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .ieee_float(f[2]), .inexact(inx[2]), .zero(zr[2]));

    function automatic int wof(input int d);
        return (d == 0) ? 32 : (d == 1) ? 16 : 64;
    endfunction

    function automatic int qof(input int d);
        return (d == 0) ? 16 : (d == 1) ? 8 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer magnitude, binade by repeated halving, rounding
    // by quotient/remainder against one half ulp. Returns {inexact, zero, float}.
    function automatic logic [33:0] model(input logic [63:0] x, input int w,
                                          input int q, input bit rm);
        logic [64:0] v, m, sig, rem, half;
        int e;
        bit neg, inx_b;
        v = '0;
        for (int i = 0; i < w; i++) v[i] = x[i];
        neg = x[w-1];
        m = neg ? ((65'd1 << w) - v) : v;
        if (m == 0) return {1'b0, 1'b1, 32'h0};
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e > 23) begin
            sig   = m >> (e - 23);
            rem   = m - (sig << (e - 23));
            half  = 65'd1 << (e - 24);
            inx_b = (rem != 0);
            if (rm && (rem > half || (rem == half && sig[0]))) sig = sig + 65'd1;
            if (sig == (65'd1 << 24)) begin
                sig = 65'd1 << 23;
                e++;
            end
        end else begin
            sig   = m << (23 - e);
            inx_b = 1'b0;
        end
        return {inx_b, 1'b0, neg, 8'(127 + e - q), sig[22:0]};
    endfunction

    task automatic send(input int d, input logic [63:0] x, input bit rm, input logic [33:0] e);
        int n;
        iv[d] = 1'b1;
        fp[d] = x;
        rmq[d] = rm;
        n = 0;
        @(negedge clk);
        while (!ir[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ir[d]) begin
            fifo[d][wr[d] % 256] = e;
            wr[d]++;
        end else begin
            chk("accept_timeout", 64'(ir[d]), 64'd1);
        end
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 200 && (wr[0] != rd[0] || wr[1] != rd[1] || wr[2] != rd[2])) begin
            @(posedge clk);
            n++;
        end
        for (int d = 0; d < 3; d++) chk($sformatf("drain%0d", d), 64'(rd[d]), 64'(wr[d]));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor: in-order scoreboard plus stability while stalled.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                hv[d] = 1'b0;
                rd[d] = wr[d];
            end else begin
                mon_cur = {inx[d], zr[d], f[d]};
                if (hv[d] && ov[d]) chk($sformatf("hold%0d", d), 64'(mon_cur), 64'(hold[d]));
                if (ov[d] && ordy[d]) begin
                    if (wr[d] == rd[d]) begin
                        chk($sformatf("spurious%0d", d), 64'(ov[d]), 64'd0);
                    end else begin
                        chk($sformatf("res%0d", d), 64'(mon_cur), 64'(fifo[d][rd[d] % 256]));
                        rd[d]++;
                    end
                end
                hv[d]   = ov[d] && !ordy[d];
                hold[d] = mon_cur;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] bp [5];
        logic [7:0]  ovs;
        logic        stale;
        logic [63:0] x;
        int          idx, d, kind;
        bit          rm;

        rst = 1'b1; iv = '0; ordy = 3'b111; fp = '0; rmq = '0; rnd_on = 1'b0;
        for (int k = 0; k < 3; k++) begin wr[k] = 0; rd[k] = 0; hv[k] = 1'b0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(ov[0]), 64'd0);
        chk("rst_float", 64'(f[0]), 64'd0);
        chk("rst_inexact", 64'(inx[0]), 64'd0);
        chk("rst_zero", 64'(zr[0]), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", 64'(ir[0]), 64'd1);

        // Latency: out_valid on the third edge counting the transfer edge
        send(0, 64'h4000, 1'b1, {2'b00, 32'h3E800000});
        chk("lat_e1", 64'(ov[0]), 64'd0);
        @(posedge clk); #1 chk("lat_e2", 64'(ov[0]), 64'd0);
        @(posedge clk); #1 chk("lat_e3", 64'(ov[0]), 64'd1);
        chk("lat_val", 64'(f[0]), 64'h3E800000);
        drain();

        // Directed values, back to back
        send(0, 64'h00000CCC, 1'b1, {2'b00, 32'h3D4CC000});
        send(0, 64'hFFFF0000, 1'b1, {2'b00, 32'hBF800000});
        send(0, 64'h80000000, 1'b1, {2'b00, 32'hC7000000});
        send(0, 64'h00000000, 1'b1, {2'b01, 32'h00000000});
        send(0, 64'h7FFFFFFF, 1'b1, {2'b10, 32'h47000000});
        send(0, 64'h7FFFFFFF, 1'b0, {2'b10, 32'h46FFFFFF});
        drain();

        // Reset with three transactions in flight
        send(0, 64'h00010000, 1'b1, model(64'h00010000, 32, 16, 1'b1));
        send(0, 64'h00020000, 1'b1, model(64'h00020000, 32, 16, 1'b1));
        send(0, 64'h00030000, 1'b1, model(64'h00030000, 32, 16, 1'b1));
        #2 rst = 1'b1;
        #1 chk("mid_out_valid", 64'(ov[0]), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        stale = 1'b0;
        repeat (5) begin @(negedge clk); stale = stale | ov[0]; end
        chk("mid_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;
        send(0, 64'hFFFF0000, 1'b1, {2'b00, 32'hBF800000});
        drain();

        // Backpressure: five offers against a stalled output
        for (int i = 0; i < 5; i++) bp[i] = 64'(i + 1) * 64'h00018000;
        ordy[0] = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            iv[0] = 1'b1; fp[0] = bp[idx]; rmq[0] = 1'b1;
            @(negedge clk);
            if (ir[0]) begin
                fifo[0][wr[0] % 256] = model(bp[idx], 32, 16, 1'b1);
                wr[0]++;
                idx++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", 64'(idx), 64'd3);
        chk("bp_in_ready", 64'(ir[0]), 64'd0);
        ordy[0] = 1'b1;
        ovs = '0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 5) begin iv[0] = 1'b1; fp[0] = bp[idx]; end
            else iv[0] = 1'b0;
            @(negedge clk);
            ovs[c] = ov[0];
            if (iv[0] && ir[0]) begin
                fifo[0][wr[0] % 256] = model(bp[idx], 32, 16, 1'b1);
                wr[0]++;
                idx++;
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        chk("bp_burst", 64'(ovs), 64'h1F);
        drain();

        // Randomised traffic on all three widths with random backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 450; i++) begin
                    d = $urandom_range(0, 2);
                    x = {$urandom(), $urandom()};
                    kind = $urandom_range(0, 7);
                    case (kind)
                        1: x = x >> $urandom_range(0, 63);
                        2: x = -(x >> $urandom_range(0, 63));
                        3: begin
                            x = 64'd1 << $urandom_range(0, 63);
                            if ($urandom_range(0, 1) == 1) x = -x;
                        end
                        4: x = (64'h1000000 | 64'($urandom_range(0, 16777215))) << $urandom_range(0, 30);
                        5: x = 64'd0;
                        6: x = 64'h7FFFFFFFFFFFFFFF >> (64 - wof(d));
                        7: x = 64'd1 << (wof(d) - 1);
                        default: ;
                    endcase
                    rm = bit'($urandom_range(0, 1));
                    send(d, x, rm, model(x, wof(d), qof(d), rm));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk); #1;
                    for (int k = 0; k < 3; k++) ordy[k] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ordy = 3'b111;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fixed_float_pipe.md
Name: fixed_float_pipe

Overview:
- Pipelined, parametrised signed fixed-point Q(m,n) to IEEE-754 single-precision converter with a valid/ready handshake on both sides.
- Successor to the combinational fixed_float converter. Adds configurable input width, per-transaction rounding mode, inexact/zero flags and backpressure.
- Sits between the fixed-point front end and the Adder_Subtractor operand inputs.

Parameters:
- W, 32, input fixed-point width in bits, two's complement; legal range 8..64.
- Q, 16, number of fractional bits; legal range 0..W-1; (W-1-Q) must be 127 or less.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  converter can accept a transaction this cycle.
- fixed_point  input  W  signed fixed-point operand, value = fixed_point / 2^Q.
- round_mode  input  1  0 = truncate toward zero, 1 = round to nearest, ties to even (RNE).
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- ieee_float  output  32  IEEE-754 single-precision result.
- inexact  output  1  one or more nonzero bits were discarded.
- zero  output  1  input was exactly 0.

Behaviour:
- Reset, asynchronous: all stage valids cleared. out_valid=0, ieee_float=0, inexact=0, zero=0. in_ready is 1 once rst deasserts.
- A transfer occurs when valid and ready are both high on a clock edge. round_mode is captured with fixed_point and travels with it.
- Pipeline has 3 stages. Latency is 3 cycles from input transfer to out_valid, given no stalls. Throughput is 1 per cycle.
- Stall rule: global advance en = !out_valid | out_ready, and in_ready = en.
  - When en=0 every stage holds its data and its valid.
  - Bubbles are not collapsed.
  - Results emerge in input order; nothing is dropped or duplicated.
- Stage 1:
  - sign = fixed_point[W-1].
  - mag = |fixed_point| as a W-bit unsigned value.
  - The most negative input 2^(W-1) is representable unsigned; no overflow.
- Stage 2:
  - p = index of the leading one of mag.
  - zero = (mag==0).
- Stage 3, normalise and round:
  - Significand = mag shifted so bit p becomes the hidden bit.
  - Exponent field = 127 + p - Q.
  - If p > 23, bits below p-23 are dropped. guard = bit p-24; sticky = OR of the lower bits.
  - inexact = guard | sticky.
  - RNE: increment the mantissa if guard & (sticky | mantissa LSB).
  - Truncate: never increment.
  - Mantissa carry-out: mantissa becomes 0 and the exponent increments.
  - If p is 23 or less, the value is exact and inexact=0.
- Zero input: result is +0 (0x00000000) with zero=1 and inexact=0. -0 is never produced.
- Denormal, infinity and NaN outputs cannot occur within the legal parameter range, so no exception output is needed.
- Outputs are registered. ieee_float, inexact and zero hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation flushes all in-flight transactions. No output appears for them.
- in_valid with in_ready=0: the input must be held by the source and is not consumed.
- Out-of-range parameters: elaboration-time $error.

Test Plan:
- Exact positive values, W=32, Q=16, RNE:
  - fixed_point=0x00004000 (0.25) -> ieee_float=0x3E800000, inexact=0, exactly 3 cycles after the transfer.
  - fixed_point=0x00000CCC (0.05 truncated) -> 0x3D4CC000, inexact=0.
- Sign and extremes:
  - 0xFFFF0000 (-1.0) -> 0xBF800000.
  - 0x80000000 -> 0xC7000000 (-32768.0).
  - 0x00000000 -> 0x00000000 with zero=1.
- Rounding:
  - 0x7FFFFFFF with round_mode=1 -> 0x47000000, inexact=1 (carry into the exponent).
  - Same input with round_mode=0 -> 0x46FFFFFF, inexact=1.
  - Back-to-back, the two transactions emerge in order.
- Backpressure:
  - Hold out_ready=0 and offer 5 consecutive inputs: exactly 3 are accepted, in_ready=0 from the 3rd acceptance onward, and the output holds stable.
  - Release out_ready: all 5 results appear in order, one per cycle.
- Reset mid-flight: assert rst asynchronously, between edges, with 3 transactions in flight -> out_valid=0 immediately. After release, no stale results appear and the next input converts correctly.
- Parameter sweep, W=16 with Q=8 and W=64 with Q=0: random inputs compared against a real-arithmetic reference model with matching rounding. Flags are checked every transaction.
